// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: frame state encodings and line levels.
// Used by both the transmit framer and the receiver.
package uart_defs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_e;

    localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/uart_tick_det.sv
// Rising-edge detector for the baud generator's slow clock, gated by the enable.
// The first enabled cycle is masked so a stale history bit cannot produce a tick.
module uart_tick_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_uart_i,
    input  logic en_i,
    output logic tick_o
);

    logic clk_uart_q;
    logic en_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_uart_q <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            clk_uart_q <= clk_uart_i;
            en_q       <= en_i;
        end
    end

    assign tick_o = en_i & en_q & clk_uart_i & ~clk_uart_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit boundaries come from ticks derived from the baud generator's slow clock.
module uart_tx_frame
    import uart_defs_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_uart,
    output logic              baud_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              send,
    output logic              ready,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              tick;

    assign baud_en = (state_q != IDLE);
    assign ready   = (state_q == IDLE);
    assign busy    = ~ready;
    assign tx      = tx_q;
    assign done    = done_q;

    uart_tick_det u_tick_det (
        .clk_i      (clk),
        .rst_i      (rst),
        .clk_uart_i (clk_uart),
        .en_i       (baud_en),
        .tick_o     (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE;
                if (send) begin
                    shift_d   = data_in;
                    par_en_d  = parity_en;
                    // Parity is fixed at accept so later input changes cannot leak in.
                    par_bit_d = ^data_in ^ parity_odd;
                    stop2_d   = stop2;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP1;
                        tx_d    = par_en_q ? par_bit_q : TX_IDLE;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP1;
                    tx_d    = TX_IDLE;
                end
            end
            STOP1: begin
                if (tick) begin
                    tx_d = TX_IDLE;
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= TX_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer that sits directly downstream of the baud-rate generator and consumes its slow clock output.
- Accepts one parallel word per valid/ready handshake.
- Enables the baud generator only while a frame is in flight.
- Serialises the frame LSB-first as: start bit, data bits, optional parity bit, then 1 or 2 stop bits.
- Drives the idle-high tx line toward the pad.

Parameters:
DATA_W, 8, number of data bits per frame (5..8 supported).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
clk_uart  in  1  slow clock from the baud generator (level signal, synchronous to clk).
baud_en  out  1  enable to the baud generator; high while a frame is in flight.
data_in  in  DATA_W  word to send; sampled on accept.
send  in  1  request/valid.
ready  out  1  high when idle; accept = send & ready.
parity_en  in  1  1 = insert a parity bit; sampled on accept.
parity_odd  in  1  1 = odd parity, 0 = even; sampled on accept.
stop2  in  1  1 = two stop bits, 0 = one; sampled on accept.
tx  out  1  serial line; idles high.
busy  out  1  equal to ~ready.
done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
Reset (rst sampled high at a clk edge):
- state=IDLE, tx=1, baud_en=0, ready=1, busy=0, done=0, edge-detect history=0.
- Takes effect at the next edge even mid-frame; the frame is abandoned and tx returns high one cycle later.

Edge detect:
- tick = clk_uart & ~clk_uart_q, where clk_uart_q is clk_uart registered.
- tick is forced to 0 while baud_en=0, and in the cycle baud_en first asserts, so no stale edge is counted.

Accept (IDLE and send=1):
- Latch data_in, parity_en, parity_odd and stop2 into a shift register and config flags.
- Next cycle: state=START, tx=0, baud_en=1, ready=0.
- send while not ready is ignored, with no queuing.

States and transitions (every transition except accept happens only on tick):
- START: tx=0; on tick -> DATA, bit counter=0.
- DATA: tx=shift[0]; on tick shift right and increment the counter; after DATA_W ticks -> PARITY if parity_en, else STOP1.
- PARITY: tx = ^data_latched ^ parity_odd; on tick -> STOP1.
- STOP1: tx=1; on tick -> STOP2 if stop2, else finish.
- STOP2: tx=1; on tick -> finish.

Bit timing:
- Each bit is held from the tick (or the accept cycle, for the start bit) until the next tick.
- tx, state and counters are registered, so a tick in cycle n changes tx in cycle n+1.

Finish:
- Next cycle: state=IDLE, done=1 for exactly one cycle, baud_en=0, ready=1, tx stays 1.
- A send in the same cycle as done is accepted, because ready=1 in that cycle: back-to-back frames with no extra idle bit.

Counter and parity widths:
- Bit counter is ceil(log2(DATA_W+1)) bits wide and saturates by state change, never by wrap.
- Parity covers exactly DATA_W bits of the latched word.

Input changes:
- Changes to data_in or the config inputs during a frame have no effect on that frame.

Decomposition:
- Shared package/header uart_defs: state encodings (IDLE, START, DATA, PARITY, STOP1, STOP2) and the TX_IDLE=1 level constant. The receiver reuses them.
- One sub-module, uart_tick_det: registers clk_uart and produces the gated single-cycle tick. It is also reusable by the receiver.
- The FSM, shift register and counter live in the top module.

Test Plan:
All scenarios use a bench model of the baud generator in which clk_uart toggles every 4 clk cycles while baud_en=1 (8 cycles per bit).
1. Reset then idle: hold rst for 2 cycles, send=0 for 200 cycles -> tx=1, ready=1, baud_en=0, done=0 throughout.
2. Send 0xA5, parity off, 1 stop:
   - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
   - done pulses once, 1 cycle.
   - ready low from the cycle after accept until done.
3. Send 0x03, parity_en=1, parity_odd=0, stop2=1 -> 0,1,1,0,0,0,0,0,0,parity 0,1,1. Repeat with parity_odd=1 -> parity bit 1.
4. Back-to-back frames:
   - Sends 0x55 and 0x0F, with the second send held high across the done cycle.
   - The second start bit begins in the cycle after done.
   - No extra idle bit between frames.
   - Both frames decode correctly.
5. Input hold and stray sends: send 0xFF, change data_in to 0x00 and pulse send mid-frame -> transmitted data stays 0xFF, and only one done pulse occurs.
6. Reset mid-frame: assert rst during DATA bit 3 -> next cycle tx=1, baud_en=0, ready=1. A new send of 0x81 then completes correctly.
